// File: rtl/seqdet_pkg.sv
// Shared constants, types and helpers for the serial pattern detector.
package seqdet_pkg;

  localparam int SEQDET_PAT_W_MAX = 32;

  typedef enum logic [1:0] {
    PRIO_CLR,
    PRIO_LOAD,
    PRIO_BIT
  } seqdet_prio_e;

  function automatic int seqdet_fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seqdet_hist_shreg.sv
// History shift register with a fill counter that saturates at the pattern length W.
// Only W-1 history bits are stored; the newest bit is compared directly from the input.
module seqdet_hist_shreg
  import seqdet_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         shift,
  input  logic                         clr,
  input  logic                         din,
  output logic [W-2:0]                 hist,
  output logic [seqdet_fill_w(W)-1:0]  fill
);

  localparam int FW = seqdet_fill_w(W);
  localparam int HW = W - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= (hist << 1) | HW'(din);
      if (fill != FW'(W)) fill <= fill + FW'(1);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern and per-bit overlap mode.
// Define SEQDET_COUNT_EN to add the saturating match counter and its o_det_cnt port.
module seq_pattern_detector
  import seqdet_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic             i_seq,
  input  logic             i_overlap,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pat,
  input  logic             i_clr,
  output logic             o_det
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_det_cnt
`endif
);

  localparam int FW = seqdet_fill_w(PAT_W);

  if (PAT_W < 2 || PAT_W > SEQDET_PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W=%0d outside 2..%0d", PAT_W, SEQDET_PAT_W_MAX);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_pattern_detector: CNT_W=%0d must be at least 1", CNT_W);
  end

  seqdet_prio_e     prio;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic             accept;
  logic             match;
  logic             sh_clr;

  always_comb begin
    prio = PRIO_BIT;
    if (i_clr)           prio = PRIO_CLR;
    else if (i_pat_load) prio = PRIO_LOAD;
  end

  assign accept = i_valid && (prio == PRIO_BIT);
  assign match  = accept && (fill >= FW'(PAT_W - 1)) && ({hist, i_seq} == pat_q);
  // Clearing history on load or a non-overlap hit is harmless: a new match needs PAT_W fresh bits.
  assign sh_clr = (prio != PRIO_BIT) || (match && !i_overlap);

  seqdet_hist_shreg #(.W(PAT_W)) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (accept),
    .clr   (sh_clr),
    .din   (i_seq),
    .hist  (hist),
    .fill  (fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_INIT;
      o_det <= 1'b0;
    end else begin
      if (prio == PRIO_LOAD) pat_q <= i_pat;
      o_det <= match;
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_det_cnt <= '0;
    end else if (prio == PRIO_CLR) begin
      o_det_cnt <= '0;
    end else if (match && (o_det_cnt != {CNT_W{1'b1}})) begin
      o_det_cnt <= o_det_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
